alu_exec_pipe: RTL
==================

// Module: alu_exec_pipe
// PURPOSE
//  Parametrised integer execution unit between the ALU reservation station and the ReorderBuffer.
//  Computes RV32I ALU, branch and jump results, including the redirect PC and jump flag.
//  The pipeline depth is configurable; valid/ready backpressure, a flush for mispredict recovery
//  and a mispredict flag (actual vs. predicted direction) are added on top of single-cycle issue.
// PARAMETERS
//  XLEN      32  datapath/PC width; imm arrives already sign-extended to XLEN
//  ROB_W     4   ROB id width
//  OP_W      6   op-id width (encodings from shared package)
//  STAGES    2   pipeline register stages, >=1; latency in cycles without backpressure
// PORTS
//  clk            in   1      clock
//  rst            in   1      asynchronous reset, active-low
//  rdy            in   1      global enable; 0 freezes all state
//  flush          in   1      ROB misprediction clear; kills all in-flight ops
//  in_valid       in   1      RS offers an op
//  in_ready       out  1      unit accepts the op this cycle
//  in_op          in   OP_W   op id
//  in_pc          in   XLEN   instruction PC
//  in_rs1/in_rs2  in   XLEN   operand values
//  in_imm         in   XLEN   sign-extended immediate
//  in_rob_id      in   ROB_W  destination ROB entry
//  in_pred_taken  in   1      fetch-side prediction for this op
//  out_valid      out  1      result present at pipe tail
//  out_ready      in   1      ROB/CDB accepts the result
//  out_rob_id     out  ROB_W  ROB entry
//  out_value      out  XLEN   rd value (0/1 for branches)
//  out_target_pc  out  XLEN   next PC the op resolves to
//  out_jump       out  1      control transfer taken
//  out_mispredict out  1      redirect is required
// BEHAVIOUR
//  Reset (rst=0, async): all stage valid bits 0, all data regs 0; outputs read 0; in_ready=1 after release.
//  Compute: combinational from the in_* ports; the result is captured in stage 1 and shifted to stage STAGES.
//  - Handshake: transfer on valid&ready at a rising edge. Each stage loads when it is empty or its
//    successor moves (bubbles collapse). in_ready = !v[1] | stage1 moves. Tail moves on out_ready.
//  - out_* hold stable while out_valid & !out_ready.
//  - Latency: accepted at edge t, visible at out_valid after edge t+STAGES-1 when unstalled.
//    Throughput: 1 op/cycle.
//  flush=1: at the next edge, every v[] is cleared. An input offered in the same cycle is dropped
//    (in_ready may still read 1). flush has priority over all moves.
//  rdy=0: no state changes, in_ready=0, out_valid holds; flush and reset still take effect.
//  Arithmetic, all mod 2^XLEN; pc+4 wraps:
//  - LUI value=imm. AUIPC value=pc+imm.
//  - ADD/SUB/AND/OR/XOR and I-forms use rs1 op rs2 or rs1 op imm.
//  - SLT/SLTI compare signed. SLTU/SLTIU compare unsigned; SLTIU uses the sign-extended imm.
//  - Shift amount is operand[$clog2(XLEN)-1:0] only. SRA/SRAI shift arithmetically (signed rs1).
//  - JAL: value=pc+4, target=pc+imm, jump=1. JALR: value=pc+4, target=(rs1+imm)&~1, jump=1,
//    mispredict=1 always (no target predictor).
//  - Bxx: value=cond, jump=cond, target=cond ? pc+imm : pc+4; mispredict=cond^pred_taken.
//  - Non-control ops: target=pc+4, jump=0, mispredict=0.
//  - Undefined op: value=0, target=pc+4, jump=0, mispredict=0, still delivered so the ROB entry retires.
// STRUCTURE
//  Shared package/defines: op-id encodings (LUI..SRAI), XLEN/ROB_W defaults, True/False.
//  Sub-module alu_exec_core: purely combinational op->{value,target,jump,mispredict}.
//  The top holds the STAGES-deep elastic register chain plus flush/rdy control.
// TESTING
//  1 STAGES=2: ADD 5+(-3), rob 3, out_ready=1 -> out_valid 2 cycles later: value=2, target=pc+4, jump=0.
//  2 BLT rs1=-1 rs2=1, pc=0x100, imm=0x20, pred=0 -> jump=1, target=0x120, mispredict=1;
//    BLTU same operands -> jump=0, target=0x104, mispredict=0.
//  3 SRAI rs1=0x80000000, imm=0x21 -> shamt 1, value=0xC0000000;
//    JALR rs1=0x203, imm=0 -> target=0x202, value=pc+4.
//  4 Back-to-back 4 ops, out_ready low 3 cycles -> in_ready drops once the pipe is full,
//    out_* held stable, all 4 retire in order with no loss or duplication.
//  5 flush with 2 ops in flight plus in_valid=1 -> no out_valid for any of them;
//    the next op after flush arrives after STAGES cycles.
//  6 rst asserted mid-stream (async, between edges) -> out_valid=0 immediately;
//    rdy=0 for 3 cycles -> state frozen, then resumes exactly.

Source files
------------

// File: rtl/alu_exec_pipe_pkg.sv
// rtl/alu_exec_pipe_pkg.sv - shared op-id encodings, widths and op classification
package alu_exec_pipe_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int ROB_W_DEF = 4;
  localparam int OP_W_DEF  = 6;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  localparam int OP_LUI   = 0;
  localparam int OP_AUIPC = 1;
  localparam int OP_JAL   = 2;
  localparam int OP_JALR  = 3;
  localparam int OP_BEQ   = 4;
  localparam int OP_BNE   = 5;
  localparam int OP_BLT   = 6;
  localparam int OP_BGE   = 7;
  localparam int OP_BLTU  = 8;
  localparam int OP_BGEU  = 9;
  localparam int OP_ADD   = 10;
  localparam int OP_SUB   = 11;
  localparam int OP_SLL   = 12;
  localparam int OP_SLT   = 13;
  localparam int OP_SLTU  = 14;
  localparam int OP_XOR   = 15;
  localparam int OP_SRL   = 16;
  localparam int OP_SRA   = 17;
  localparam int OP_OR    = 18;
  localparam int OP_AND   = 19;
  localparam int OP_ADDI  = 20;
  localparam int OP_SLTI  = 21;
  localparam int OP_SLTIU = 22;
  localparam int OP_XORI  = 23;
  localparam int OP_ORI   = 24;
  localparam int OP_ANDI  = 25;
  localparam int OP_SLLI  = 26;
  localparam int OP_SRLI  = 27;
  localparam int OP_SRAI  = 28;

  typedef enum logic [1:0] {
    CLS_ALU,
    CLS_BRANCH,
    CLS_JAL,
    CLS_JALR
  } op_class_t;

  function automatic op_class_t op_class(input int op);
    case (op)
      OP_JAL:  return CLS_JAL;
      OP_JALR: return CLS_JALR;
      OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: return CLS_BRANCH;
      default: return CLS_ALU;
    endcase
  endfunction

endpackage

// File: rtl/alu_exec_pipe_core.sv
// rtl/alu_exec_pipe_core.sv - combinational op -> {value, target, jump, mispredict}
module alu_exec_core
  import alu_exec_pipe_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int OP_W = OP_W_DEF
) (
  input  logic [OP_W-1:0] op,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic [XLEN-1:0] imm,
  input  logic            pred_taken,
  output logic [XLEN-1:0] value,
  output logic [XLEN-1:0] target,
  output logic            jump,
  output logic            mispredict
);

  localparam int SH_W = $clog2(XLEN);

  int              opi;
  op_class_t       cls;
  logic            cond;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] pc_plus_imm;
  logic [XLEN-1:0] jalr_sum;
  logic [SH_W-1:0] sh_r;
  logic [SH_W-1:0] sh_i;

  always_comb begin
    opi         = int'(op);
    cls         = op_class(opi);
    pc_plus4    = pc + XLEN'(4);
    pc_plus_imm = pc + imm;
    jalr_sum    = rs1 + imm;
    sh_r        = rs2[SH_W-1:0];
    sh_i        = imm[SH_W-1:0];
    cond        = FALSE;
    value       = '0;

    case (opi)
      OP_LUI:   value = imm;
      OP_AUIPC: value = pc_plus_imm;
      OP_JAL,
      OP_JALR:  value = pc_plus4;
      OP_BEQ:   cond  = (rs1 == rs2);
      OP_BNE:   cond  = (rs1 != rs2);
      OP_BLT:   cond  = ($signed(rs1) < $signed(rs2));
      OP_BGE:   cond  = ($signed(rs1) >= $signed(rs2));
      OP_BLTU:  cond  = (rs1 < rs2);
      OP_BGEU:  cond  = (rs1 >= rs2);
      OP_ADD:   value = rs1 + rs2;
      OP_SUB:   value = rs1 - rs2;
      OP_SLL:   value = rs1 << sh_r;
      OP_SLT:   value = XLEN'($signed(rs1) < $signed(rs2));
      OP_SLTU:  value = XLEN'(rs1 < rs2);
      OP_XOR:   value = rs1 ^ rs2;
      OP_SRL:   value = rs1 >> sh_r;
      OP_SRA:   value = XLEN'($signed(rs1) >>> sh_r);
      OP_OR:    value = rs1 | rs2;
      OP_AND:   value = rs1 & rs2;
      OP_ADDI:  value = rs1 + imm;
      OP_SLTI:  value = XLEN'($signed(rs1) < $signed(imm));
      OP_SLTIU: value = XLEN'(rs1 < imm);
      OP_XORI:  value = rs1 ^ imm;
      OP_ORI:   value = rs1 | imm;
      OP_ANDI:  value = rs1 & imm;
      OP_SLLI:  value = rs1 << sh_i;
      OP_SRLI:  value = rs1 >> sh_i;
      OP_SRAI:  value = XLEN'($signed(rs1) >>> sh_i);
      default:  value = '0;
    endcase

    // JAL target is fixed, so it only mispredicts if fetch did not redirect
    target     = pc_plus4;
    jump       = FALSE;
    mispredict = FALSE;
    case (cls)
      CLS_BRANCH: begin
        value      = XLEN'(cond);
        jump       = cond;
        target     = cond ? pc_plus_imm : pc_plus4;
        mispredict = cond ^ pred_taken;
      end
      CLS_JAL: begin
        jump       = TRUE;
        target     = pc_plus_imm;
        mispredict = !pred_taken;
      end
      CLS_JALR: begin
        jump       = TRUE;
        target     = jalr_sum & {{(XLEN-1){1'b1}}, 1'b0};
        mispredict = TRUE;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_exec_pipe.sv
// rtl/alu_exec_pipe.sv - elastic STAGES-deep execution pipe with flush and global enable
module alu_exec_pipe
  import alu_exec_pipe_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int ROB_W  = ROB_W_DEF,
  parameter int OP_W   = OP_W_DEF,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdy,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  in_op,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [XLEN-1:0]  in_rs1,
  input  logic [XLEN-1:0]  in_rs2,
  input  logic [XLEN-1:0]  in_imm,
  input  logic [ROB_W-1:0] in_rob_id,
  input  logic             in_pred_taken,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ROB_W-1:0] out_rob_id,
  output logic [XLEN-1:0]  out_value,
  output logic [XLEN-1:0]  out_target_pc,
  output logic             out_jump,
  output logic             out_mispredict
);

  localparam int PW = ROB_W + 2 * XLEN + 2;

  logic [XLEN-1:0] c_value;
  logic [XLEN-1:0] c_target;
  logic            c_jump;
  logic            c_mispredict;

  alu_exec_core #(
    .XLEN (XLEN),
    .OP_W (OP_W)
  ) u_core (
    .op         (in_op),
    .pc         (in_pc),
    .rs1        (in_rs1),
    .rs2        (in_rs2),
    .imm        (in_imm),
    .pred_taken (in_pred_taken),
    .value      (c_value),
    .target     (c_target),
    .jump       (c_jump),
    .mispredict (c_mispredict)
  );

  logic [STAGES-1:0] v_q;
  logic [STAGES-1:0] v_d;
  logic [PW-1:0]     pay_q [STAGES];
  logic [PW-1:0]     pay_d [STAGES];
  logic [STAGES:0]   src_v;
  logic [PW-1:0]     src_pay [STAGES+1];
  logic [STAGES:0]   go;

  // go[i]: stage i may load this cycle; go[STAGES] is the consumer side
  always_comb begin
    src_v[0]   = in_valid;
    src_pay[0] = {in_rob_id, c_value, c_target, c_jump, c_mispredict};
    for (int i = 0; i < STAGES; i++) begin
      src_v[i+1]   = v_q[i];
      src_pay[i+1] = pay_q[i];
    end

    go[STAGES] = out_ready;
    for (int i = STAGES - 1; i >= 0; i--) begin
      go[i] = !v_q[i] || go[i+1];
    end

    v_d   = v_q;
    pay_d = pay_q;
    if (flush) begin
      v_d = '0;
    end else if (rdy) begin
      for (int i = 0; i < STAGES; i++) begin
        if (go[i]) begin
          v_d[i] = src_v[i];
          if (src_v[i]) begin
            pay_d[i] = src_pay[i];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v_q <= '0;
      for (int i = 0; i < STAGES; i++) begin
        pay_q[i] <= '0;
      end
    end else begin
      v_q   <= v_d;
      pay_q <= pay_d;
    end
  end

  assign in_ready  = rdy && go[0];
  assign out_valid = v_q[STAGES-1];
  assign {out_rob_id, out_value, out_target_pc, out_jump, out_mispredict} = pay_q[STAGES-1];

endmodule
